decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Next-generation, parametrised decode stage for the BRISC-V pipeline. It replaces the purely combinational decoder with a registered stage.
- Decodes one instruction per cycle and reads the register file. Write-back data is bypassed into the read.
- Builds all five RISC-V immediate formats and computes branch and JAL targets.
- Tracks in-flight load destinations in a scoreboard and holds the stage with a valid/ready handshake on load-use hazards.
- Sits between fetch and execute.

Parameters:
CORE, 0, core index (informational only)
ADDRESS_BITS, 20, PC and target width
DATA_WIDTH, 32, register and immediate width (32 or 64)
REG_SEL_BITS, 5, register index width; register count is 2**REG_SEL_BITS

Ports:
clock  input  1  single clock for all state
reset  input  1  asynchronous, active-low reset
PC  input  ADDRESS_BITS  PC of the incoming instruction
instruction  input  32  instruction word
in_valid  input  1  fetch offers an instruction
in_ready  output  1  stage accepts the instruction this cycle
extend_sel  input  3  immediate format: 000 I, 001 S, 010 U, 011 SB, 100 UJ; other codes behave as I
write  input  1  write-back enable
write_reg  input  REG_SEL_BITS  write-back register
write_data  input  DATA_WIDTH  write-back data
flush  input  1  kill the output register and block acceptance this cycle
out_valid  output  1  output register holds a valid decoded instruction
out_ready  input  1  execute consumes the output this cycle
out_PC  output  ADDRESS_BITS  registered PC
rs1_data  output  DATA_WIDTH  registered rs1 operand
rs2_data  output  DATA_WIDTH  registered rs2 operand
rd  output  5  instruction[11:7]
opcode  output  7  instruction[6:0]
funct3  output  3  instruction[14:12]
funct7  output  7  instruction[31:25]
extend_imm  output  DATA_WIDTH  sign-extended immediate
branch_target  output  ADDRESS_BITS  PC + SB immediate
JAL_target  output  ADDRESS_BITS  PC + UJ immediate
hazard_stall  output  1  combinational: stall is due to a scoreboard or load-use hazard

Behaviour:
- Reset (asynchronous, active-low):
  - all registers cleared to 0; scoreboard cleared to 0.
  - out_valid=0; every registered output is 0.
- Register x0:
  - always reads 0; writes to x0 are ignored.
  - x0 is never marked busy and never bypassed.
- Operand usage:
  - rs1 is used unless opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111.
  - rs2 is used for STORE 0100011, BRANCH 1100011 and OP 0110011 (OP-32 0111011 as well when DATA_WIDTH=64).
- Hazards (hazard_stall=1) when any of:
  - a used rs1 or rs2 has its busy bit set;
  - the output register holds a LOAD (0000011) with out_valid=1 and rd equal to a used rs1 or rs2 (load-use);
  - the incoming instruction is a LOAD and its rd is busy (WAW).
  - A busy bit being cleared by write-back in the same cycle does not cause a hazard; the value is bypassed instead.
- Handshake:
  - in_ready = !hazard_stall && !flush && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - Latency is 1 cycle: accepted fields appear registered on the next edge with out_valid=1.
- Output register update each edge:
  - out_valid ← 1 on accept;
  - else out_valid ← 0 if out_ready or flush;
  - else hold. Held data stays stable while out_valid && !out_ready.
- Register file:
  - 2 combinational read ports, 1 write port, write on the clock edge.
  - Read bypass: if write && write_reg==rsX && write_reg!=0, rsX_data = write_data.
- Scoreboard:
  - set busy[rd] when out_valid && out_ready && opcode==LOAD && rd!=0 (at hand-off to execute, so flushed loads never set it).
  - clear busy[write_reg] when write is high.
  - Same register set and cleared in one cycle: set wins.
- Immediates:
  - I, S and SB are sign-extended to DATA_WIDTH.
  - U = {inst[31:12], 12'b0}, sign-extended from bit 31 when DATA_WIDTH=64.
  - UJ = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Targets are PC plus the immediate truncated to ADDRESS_BITS; results wrap modulo 2**ADDRESS_BITS.
- Flush:
  - clears out_valid at the next edge regardless of out_ready.
  - scoreboard untouched.
- Reset mid-operation: all state is discarded immediately; no pending write-back is remembered.

Decomposition:
- Shared package:
  - opcode constants (LOAD, STORE, BRANCH, OP, OP_32, LUI, AUIPC, JAL, JALR);
  - extend_sel encodings;
  - DATA_WIDTH legality check.
- One natural sub-module, regfile_scoreboard:
  - parametrised register array with a bypassed read;
  - busy bit vector with set/clear ports;
  - busy lookup for three indices.
- Immediate formation and the handshake logic stay in decode_stage.

Test Plan:
- Reset low mid-stream, then released → out_valid=0, outputs 0, every register reads 0, all busy bits 0.
- addi x5,x0,-1 (0xFFF00293), extend_sel=000, PC=0x100 → next cycle: out_valid=1, extend_imm=0xFFFFFFFF, rd=5, out_PC=0x100.
- lw x6,0(x1), then add x7,x6,x2 offered the next cycle, out_ready=1 → add is held (in_ready=0, hazard_stall=1) until write=1, write_reg=6, write_data=0x55; in that cycle it is accepted with rs1_data=0x55.
- beq with SB offset -8 at PC=0x4 (ADDRESS_BITS=20) → branch_target=0xFFFFC (wrap). jal with offset +0x800 at PC=0x10 → JAL_target=0x810.
- out_ready=0 for 3 cycles with in_valid=1 → outputs held stable, in_ready=0. Then flush=1 → out_valid=0 next cycle and no instruction accepted in the flush cycle.
- write to x0 with 0xDEAD, then read x0 → rs1_data=0. Same-cycle write x3=0x1234 while decoding an instruction reading x3 → bypassed 0x1234.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared constants for the BRISC-V decode stage: opcodes, immediate format
// selectors and the legal DATA_WIDTH set.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_32  = 7'b0111011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Immediate format selector; unlisted codes decode as I-type.
  typedef enum logic [2:0] {
    EXT_I  = 3'b000,
    EXT_S  = 3'b001,
    EXT_U  = 3'b010,
    EXT_SB = 3'b011,
    EXT_UJ = 3'b100
  } extend_sel_e;

  // Register and immediate width must be RV32 or RV64.
  function automatic bit data_width_ok(input int width);
    return (width == 32) || (width == 64);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch, write-back and execute-side signals of the decode stage.
// slave: the decode stage itself; master: the surrounding pipeline.
interface decode_stage_if #(
  parameter int ADDRESS_BITS = 20,
  parameter int DATA_WIDTH   = 32,
  parameter int REG_SEL_BITS = 5
);

  // fetch side
  logic [ADDRESS_BITS-1:0] PC;
  logic [31:0]             instruction;
  logic                    in_valid;
  logic                    in_ready;
  logic [2:0]              extend_sel;

  // write-back and pipeline control
  logic                    write;
  logic [REG_SEL_BITS-1:0] write_reg;
  logic [DATA_WIDTH-1:0]   write_data;
  logic                    flush;

  // execute side
  logic                    out_valid;
  logic                    out_ready;
  logic [ADDRESS_BITS-1:0] out_PC;
  logic [DATA_WIDTH-1:0]   rs1_data;
  logic [DATA_WIDTH-1:0]   rs2_data;
  logic [4:0]              rd;
  logic [6:0]              opcode;
  logic [2:0]              funct3;
  logic [6:0]              funct7;
  logic [DATA_WIDTH-1:0]   extend_imm;
  logic [ADDRESS_BITS-1:0] branch_target;
  logic [ADDRESS_BITS-1:0] JAL_target;
  logic                    hazard_stall;

  modport slave (
    input  PC, instruction, in_valid, extend_sel,
    input  write, write_reg, write_data, flush, out_ready,
    output in_ready, out_valid, out_PC, rs1_data, rs2_data, rd, opcode,
    output funct3, funct7, extend_imm, branch_target, JAL_target, hazard_stall
  );

  modport master (
    output PC, instruction, in_valid, extend_sel,
    output write, write_reg, write_data, flush, out_ready,
    input  in_ready, out_valid, out_PC, rs1_data, rs2_data, rd, opcode,
    input  funct3, funct7, extend_imm, branch_target, JAL_target, hazard_stall
  );

endinterface

// File: rtl/decode_stage_regfile_scoreboard.sv
// Register file with write-back bypass on both read ports, plus the busy-bit
// scoreboard of in-flight load destinations. x0 reads 0, is never written,
// never bypassed and never busy.
module decode_stage_regfile_scoreboard #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_SEL_BITS = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  // read ports
  input  logic [REG_SEL_BITS-1:0] rs1_sel,
  input  logic [REG_SEL_BITS-1:0] rs2_sel,
  output logic [DATA_WIDTH-1:0]   rs1_data,
  output logic [DATA_WIDTH-1:0]   rs2_data,
  // write port (also clears the busy bit of write_reg)
  input  logic                    write,
  input  logic [REG_SEL_BITS-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0]   write_data,
  // scoreboard set port
  input  logic                    set_en,
  input  logic [REG_SEL_BITS-1:0] set_reg,
  // busy lookups
  input  logic [REG_SEL_BITS-1:0] rd_sel,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic                    rd_busy
);

  localparam int NUM_REGS = 2 ** REG_SEL_BITS;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;

  // Bypassed read: x0 is hard zero, a same-cycle write-back wins over the array.
  function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [REG_SEL_BITS-1:0] sel);
    if (sel == '0)                     return '0;
    if (write && (write_reg == sel))   return write_data;
    return regs[sel];
  endfunction

  // A busy bit being cleared by this cycle's write-back is already resolved.
  function automatic logic busy_now(input logic [REG_SEL_BITS-1:0] sel);
    return busy[sel] && !(write && (write_reg == sel));
  endfunction

  // Register array write port.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the array is reset explicitly because every register must read 0
      // after reset; this costs a reset net on each flop instead of a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (write && (write_reg != '0)) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      regs[write_reg] <= write_data;
    end
  end

  // Scoreboard: clear on write-back, set on load hand-off.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      if (write) busy[write_reg] <= 1'b0;
      // NOTE: the set is written after the clear so that, for the same
      // register in the same cycle, the last non-blocking assignment (set) wins.
      if (set_en && (set_reg != '0)) busy[set_reg] <= 1'b1;
    end
  end

  // Combinational read ports.
  always_comb begin
    rs1_data = read_reg(rs1_sel);
    rs2_data = read_reg(rs2_sel);
  end

  // Busy lookups for the two sources and the destination.
  always_comb begin
    rs1_busy = busy_now(rs1_sel);
    rs2_busy = busy_now(rs2_sel);
    rd_busy  = busy_now(rd_sel);
  end

endmodule

// File: rtl/decode_stage.sv
// BRISC-V registered decode stage: decodes one instruction per cycle, reads
// the bypassed register file, forms immediates and branch/JAL targets, and
// holds fetch with a valid/ready handshake on load-use and scoreboard hazards.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int ADDRESS_BITS = 20,
  parameter int DATA_WIDTH   = 32,
  parameter int REG_SEL_BITS = 5
) (
  input  logic           clock,
  input  logic           reset,
  decode_stage_if.slave  bus
);

  if (!data_width_ok(DATA_WIDTH)) begin : g_bad_data_width
    $error("decode_stage: DATA_WIDTH must be 32 or 64");
  end
  if (CORE < 0) begin : g_bad_core
    $error("decode_stage: CORE must be non-negative");
  end

  // instruction fields of the incoming word
  logic [6:0] in_opcode;
  logic [4:0] in_rd;
  logic [4:0] in_rs1;
  logic [4:0] in_rs2;

  assign in_opcode = bus.instruction[6:0];
  assign in_rd     = bus.instruction[11:7];
  assign in_rs1    = bus.instruction[19:15];
  assign in_rs2    = bus.instruction[24:20];

  // output register
  logic                    out_valid_q;
  logic [ADDRESS_BITS-1:0] out_pc_q;
  logic [DATA_WIDTH-1:0]   rs1_q;
  logic [DATA_WIDTH-1:0]   rs2_q;
  logic [4:0]              rd_q;
  logic [6:0]              opcode_q;
  logic [2:0]              funct3_q;
  logic [6:0]              funct7_q;
  logic [DATA_WIDTH-1:0]   imm_q;
  logic [ADDRESS_BITS-1:0] branch_q;
  logic [ADDRESS_BITS-1:0] jal_q;

  // register file / scoreboard interface
  logic [DATA_WIDTH-1:0] rs1_rd_data;
  logic [DATA_WIDTH-1:0] rs2_rd_data;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  rd_busy;
  logic                  set_en;

  // A load leaving for execute marks its destination busy.
  assign set_en = out_valid_q && bus.out_ready && (opcode_q == OPC_LOAD) && (rd_q != 5'd0);

  decode_stage_regfile_scoreboard #(
    .DATA_WIDTH   (DATA_WIDTH),
    .REG_SEL_BITS (REG_SEL_BITS)
  ) u_regfile_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .rs1_sel    (REG_SEL_BITS'(in_rs1)),
    .rs2_sel    (REG_SEL_BITS'(in_rs2)),
    .rs1_data   (rs1_rd_data),
    .rs2_data   (rs2_rd_data),
    .write      (bus.write),
    .write_reg  (bus.write_reg),
    .write_data (bus.write_data),
    .set_en     (set_en),
    .set_reg    (REG_SEL_BITS'(rd_q)),
    .rd_sel     (REG_SEL_BITS'(in_rd)),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .rd_busy    (rd_busy)
  );

  // source operand usage and hazard detection
  logic uses_rs1;
  logic uses_rs2;
  logic hazard;
  logic in_ready;
  logic accept;

  // Which source registers the incoming opcode actually reads.
  always_comb begin
    uses_rs1 = !((in_opcode == OPC_LUI) || (in_opcode == OPC_AUIPC) || (in_opcode == OPC_JAL));
    uses_rs2 = (in_opcode == OPC_STORE) || (in_opcode == OPC_BRANCH) || (in_opcode == OPC_OP) ||
               ((DATA_WIDTH == 64) && (in_opcode == OPC_OP_32));
  end

  // Stall on busy sources, load-use against the output register, or a load WAW.
  always_comb begin
    hazard = 1'b0;
    if ((uses_rs1 && rs1_busy) || (uses_rs2 && rs2_busy))
      hazard = 1'b1;
    if (out_valid_q && (opcode_q == OPC_LOAD) &&
        ((uses_rs1 && (rd_q == in_rs1)) || (uses_rs2 && (rd_q == in_rs2))))
      hazard = 1'b1;
    if ((in_opcode == OPC_LOAD) && rd_busy)
      hazard = 1'b1;
  end

  assign in_ready = !hazard && !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // immediate formation
  logic [12:0]           sb_raw;
  logic [20:0]           uj_raw;
  logic [DATA_WIDTH-1:0] imm_sel;

  assign sb_raw = {bus.instruction[31], bus.instruction[7], bus.instruction[30:25],
                   bus.instruction[11:8], 1'b0};
  assign uj_raw = {bus.instruction[31], bus.instruction[19:12], bus.instruction[20],
                   bus.instruction[30:21], 1'b0};

  // Select the sign-extended immediate for the requested format.
  always_comb begin
    // NOTE: the default assignment ahead of the case keeps this block free of
    // inferred latches for any extend_sel value.
    imm_sel = DATA_WIDTH'($signed(bus.instruction[31:20]));
    case (bus.extend_sel)
      EXT_S:   imm_sel = DATA_WIDTH'($signed({bus.instruction[31:25], bus.instruction[11:7]}));
      EXT_U:   imm_sel = DATA_WIDTH'($signed({bus.instruction[31:12], 12'b0}));
      EXT_SB:  imm_sel = DATA_WIDTH'($signed(sb_raw));
      EXT_UJ:  imm_sel = DATA_WIDTH'($signed(uj_raw));
      default: imm_sel = DATA_WIDTH'($signed(bus.instruction[31:20]));
    endcase
  end

  // Output register: load on accept, drop on hand-off or flush, else hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      imm_q       <= '0;
      branch_q    <= '0;
      jal_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_pc_q    <= bus.PC;
      rs1_q       <= rs1_rd_data;
      rs2_q       <= rs2_rd_data;
      rd_q        <= in_rd;
      opcode_q    <= in_opcode;
      funct3_q    <= bus.instruction[14:12];
      funct7_q    <= bus.instruction[31:25];
      imm_q       <= imm_sel;
      branch_q    <= bus.PC + ADDRESS_BITS'($signed(sb_raw));
      jal_q       <= bus.PC + ADDRESS_BITS'($signed(uj_raw));
    end else if (bus.out_ready || bus.flush) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.hazard_stall  = hazard;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_PC        = out_pc_q;
  assign bus.rs1_data      = rs1_q;
  assign bus.rs2_data      = rs2_q;
  assign bus.rd            = rd_q;
  assign bus.opcode        = opcode_q;
  assign bus.funct3        = funct3_q;
  assign bus.funct7        = funct7_q;
  assign bus.extend_imm    = imm_q;
  assign bus.branch_target = branch_q;
  assign bus.JAL_target    = jal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (ADDRESS_BITS=20, DATA_WIDTH=32).
module tb_decode_stage;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  decode_stage_if #(.ADDRESS_BITS(20), .DATA_WIDTH(32), .REG_SEL_BITS(5)) bus ();

  decode_stage #(
    .CORE         (0),
    .ADDRESS_BITS (20),
    .DATA_WIDTH   (32),
    .REG_SEL_BITS (5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic v, input logic [19:0] pc, input logic [31:0] inst,
                       input logic [2:0] sel);
    bus.in_valid    = v;
    bus.PC          = pc;
    bus.instruction = inst;
    bus.extend_sel  = sel;
  endtask

  task automatic wb(input logic w, input logic [4:0] r, input logic [31:0] d);
    bus.write      = w;
    bus.write_reg  = r;
    bus.write_data = d;
  endtask

  task automatic test_reset();
    logic [4:0]  r;
    logic [31:0] inst;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL por_out_valid got %b want 0", bus.out_valid); end
    total++; if (bus.extend_imm !== 32'h0) begin bad++; $display("FAIL por_extend_imm got %h want 0", bus.extend_imm); end
    #3 reset = 1'b1;
    // stream: lw x9 handed off (busy[9]), x5 written, addi in the output register
    tick();
    bus.out_ready = 1'b1;
    offer(1'b1, 20'h040, 32'h0000A483, 3'b000);
    wb(1'b1, 5'd5, 32'h0000AAAA);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    offer(1'b1, 20'h044, 32'hFFF00293, 3'b000);
    tick();
    offer(1'b0, 20'h0, 32'h0, 3'b000);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got %b want 1", bus.out_valid); end
    #1 reset = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    total++; if (bus.out_PC !== 20'h0) begin bad++; $display("FAIL rst_out_PC got %h want 0", bus.out_PC); end
    total++; if (bus.extend_imm !== 32'h0) begin bad++; $display("FAIL rst_extend_imm got %h want 0", bus.extend_imm); end
    total++; if (bus.rd !== 5'd0 || bus.opcode !== 7'd0) begin bad++; $display("FAIL rst_rd_opcode got %h/%h want 0/0", bus.rd, bus.opcode); end
    #1 reset = 1'b1;
    // read every register pair through add x0,xi,xi; none may be busy or nonzero
    for (int i = 1; i < 32; i++) begin
      r    = 5'(i);
      inst = {7'b0, r, r, 3'b000, 5'd0, 7'b0110011};
      offer(1'b1, 20'(i * 4), inst, 3'b000);
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_busy_x%0d in_ready got %b want 1", i, bus.in_ready); end
      tick();
      total++; if (bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0) begin
        bad++; $display("FAIL rst_reg_x%0d got %h/%h want 0/0", i, bus.rs1_data, bus.rs2_data);
      end
    end
    offer(1'b0, 20'h0, 32'h0, 3'b000);
    tick();
  endtask

  task automatic test_i_imm();
    offer(1'b1, 20'h100, 32'hFFF00293, 3'b000);
    tick();
    offer(1'b0, 20'h0, 32'h0, 3'b000);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got %b want 1", bus.out_valid); end
    total++; if (bus.extend_imm !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_imm got %h want ffffffff", bus.extend_imm); end
    total++; if (bus.rd !== 5'd5) begin bad++; $display("FAIL addi_rd got %0d want 5", bus.rd); end
    total++; if (bus.out_PC !== 20'h100) begin bad++; $display("FAIL addi_pc got %h want 100", bus.out_PC); end
    total++; if (bus.opcode !== 7'h13 || bus.funct3 !== 3'd0) begin bad++; $display("FAIL addi_fields got %h/%h want 13/0", bus.opcode, bus.funct3); end
    // addi x1,x0,0x7FF with an undefined selector decodes as I
    offer(1'b1, 20'h104, 32'h7FF00093, 3'b111);
    tick();
    offer(1'b0, 20'h0, 32'h0, 3'b000);
    total++; if (bus.extend_imm !== 32'h000007FF) begin bad++; $display("FAIL sel7_imm got %h want 000007ff", bus.extend_imm); end
    tick();
  endtask

  task automatic test_imm_formats();
    logic [31:0] insts [4] = '{32'hFE20AE23, 32'h12345537, 32'hFE000CE3, 32'h001000EF};
    logic [2:0]  sels  [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
    logic [19:0] pcs   [4] = '{20'h200, 20'h0, 20'h4, 20'h10};
    logic [31:0] imms  [4] = '{32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFF8, 32'h00000800};
    logic        chk_bt[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        chk_jt[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [19:0] exp_bt[4] = '{20'h0, 20'h0, 20'hFFFFC, 20'h0};
    logic [19:0] exp_jt[4] = '{20'h0, 20'h0, 20'h0, 20'h00810};
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, pcs[i], insts[i], sels[i]);
      tick();
      total++; if (bus.extend_imm !== imms[i]) begin bad++; $display("FAIL imm_fmt%0d got %h want %h", i, bus.extend_imm, imms[i]); end
      if (chk_bt[i]) begin
        total++; if (bus.branch_target !== exp_bt[i]) begin bad++; $display("FAIL branch_target got %h want %h", bus.branch_target, exp_bt[i]); end
      end
      if (chk_jt[i]) begin
        total++; if (bus.JAL_target !== exp_jt[i]) begin bad++; $display("FAIL jal_target got %h want %h", bus.JAL_target, exp_jt[i]); end
      end
    end
    offer(1'b0, 20'h0, 32'h0, 3'b000);
    tick();
  endtask

  task automatic test_load_use();
    wb(1'b1, 5'd2, 32'h00000022);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    offer(1'b1, 20'h300, 32'h0000A303, 3'b000);   // lw x6,0(x1)
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL lw_accept in_ready got %b want 1", bus.in_ready); end
    tick();
    offer(1'b1, 20'h304, 32'h002303B3, 3'b000);   // add x7,x6,x2
    #1;
    total++; if (bus.hazard_stall !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL load_use stall/ready got %b/%b want 1/0", bus.hazard_stall, bus.in_ready);
    end
    tick();
    total++; if (bus.hazard_stall !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL busy_stall stall/valid got %b/%b want 1/0", bus.hazard_stall, bus.out_valid);
    end
    tick();
    total++; if (bus.hazard_stall !== 1'b1) begin bad++; $display("FAIL busy_hold stall got %b want 1", bus.hazard_stall); end
    wb(1'b1, 5'd6, 32'h00000055);
    #1;
    total++; if (bus.hazard_stall !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL wb_release stall/ready got %b/%b want 0/1", bus.hazard_stall, bus.in_ready);
    end
    tick();
    wb(1'b0, 5'd0, 32'h0);
    offer(1'b0, 20'h0, 32'h0, 3'b000);
    total++; if (bus.out_valid !== 1'b1 || bus.out_PC !== 20'h304) begin
      bad++; $display("FAIL add_issue valid/pc got %b/%h want 1/304", bus.out_valid, bus.out_PC);
    end
    total++; if (bus.rs1_data !== 32'h55) begin bad++; $display("FAIL add_rs1 got %h want 55", bus.rs1_data); end
    total++; if (bus.rs2_data !== 32'h22) begin bad++; $display("FAIL add_rs2 got %h want 22", bus.rs2_data); end
    #1;
    total++; if (bus.hazard_stall !== 1'b0) begin bad++; $display("FAIL busy_cleared stall got %b want 0", bus.hazard_stall); end
    tick();
  endtask

  task automatic test_hold_flush();
    bus.out_ready = 1'b0;
    offer(1'b1, 20'h400, 32'h7FF00093, 3'b000);
    tick();
    offer(1'b1, 20'h404, 32'hFFF00293, 3'b000);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold%0d in_ready got %b want 0", k, bus.in_ready); end
      total++; if (bus.out_valid !== 1'b1 || bus.out_PC !== 20'h400 || bus.extend_imm !== 32'h7FF) begin
        bad++; $display("FAIL hold%0d data got %b/%h/%h want 1/400/7ff", k, bus.out_valid, bus.out_PC, bus.extend_imm);
      end
      tick();
    end
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
    tick();
    bus.flush = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.out_PC !== 20'h400) begin
      bad++; $display("FAIL flush_kill valid/pc got %b/%h want 0/400", bus.out_valid, bus.out_PC);
    end
    tick();
    offer(1'b0, 20'h0, 32'h0, 3'b000);
    total++; if (bus.out_valid !== 1'b1 || bus.out_PC !== 20'h404) begin
      bad++; $display("FAIL post_flush valid/pc got %b/%h want 1/404", bus.out_valid, bus.out_PC);
    end
    tick();
  endtask

  task automatic test_x0_bypass();
    wb(1'b1, 5'd0, 32'h0000DEAD);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    offer(1'b1, 20'h500, 32'h00000093, 3'b000);   // addi x1,x0,0
    tick();
    total++; if (bus.rs1_data !== 32'h0) begin bad++; $display("FAIL x0_read got %h want 0", bus.rs1_data); end
    wb(1'b1, 5'd0, 32'h0000DEAD);                 // same-cycle x0 write is not bypassed
    tick();
    total++; if (bus.rs1_data !== 32'h0) begin bad++; $display("FAIL x0_bypass got %h want 0", bus.rs1_data); end
    wb(1'b1, 5'd3, 32'h00001234);
    offer(1'b1, 20'h504, 32'h00318233, 3'b000);   // add x4,x3,x3
    tick();
    wb(1'b0, 5'd0, 32'h0);
    total++; if (bus.rs1_data !== 32'h1234 || bus.rs2_data !== 32'h1234) begin
      bad++; $display("FAIL bypass_x3 got %h/%h want 1234/1234", bus.rs1_data, bus.rs2_data);
    end
    offer(1'b1, 20'h508, 32'h00318233, 3'b000);
    tick();
    offer(1'b0, 20'h0, 32'h0, 3'b000);
    total++; if (bus.rs1_data !== 32'h1234 || bus.out_PC !== 20'h508) begin
      bad++; $display("FAIL stored_x3 got %h/%h want 1234/508", bus.rs1_data, bus.out_PC);
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    offer(1'b0, 20'h0, 32'h0, 3'b000);
    wb(1'b0, 5'd0, 32'h0);
    test_reset();
    test_i_imm();
    test_imm_formats();
    test_load_use();
    test_hold_flush();
    test_x0_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
